// File: rtl/dram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_arbiter_if
// Bundle of the CPU, DMA and RAM-port signals around the DataRam arbiter.
//   master : the environment side (drives requests and ram_dout, observes
//            grants, read data, stall and performance counter)
//   slave  : the arbiter side (dram_arbiter)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> MEM-stage request,  cpu_rdata/cpu_stall <-
//   dma_req/dma_we/dma_addr/dma_wdata -> DMA request,        dma_rdata/dma_ack   <-
//   ram_we/ram_addr/ram_din           <- RAM port,           ram_dout            ->
//   dma_owner, stall_cycles           <- status / performance
// -----------------------------------------------------------------------------
interface dram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        dma_owner;
  logic [15:0] stall_cycles;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  dma_owner, stall_cycles
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output dma_owner, stall_cycles
  );
endinterface

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares the single-port DataRam between the pipeline MEM stage (priority)
// and a DMA/debug loader. DMA gets idle CPU cycles for free; after MAX_WAIT
// consecutive denied cycles it takes the RAM by force for up to BURST cycles
// and the pipeline is stalled while it does so.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - dram_arbiter_if.slave (CPU, DMA and RAM-port signals)
// Parameters:
//   MAX_WAIT (1..15) - denied DMA cycles before forced takeover
//   BURST    (1..15) - maximum length of a forced DMA burst
// Build option:
//   ARB_PERF_EN - when defined, stall_cycles counts stalled cycles
//                 (saturating); otherwise stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module dram_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int BURST    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dram_arbiter_if.slave   bus
);

  localparam logic [0:0] CPU_OWN = 1'b0;
  localparam logic [0:0] DMA_OWN = 1'b1;

  localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic cpu_gnt;
  logic dma_gnt;
  logic dma_denied;

  // Grant decode: zero-latency, purely from state and requests.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (state_q == DMA_OWN) begin
      dma_gnt = bus.dma_req;
      cpu_gnt = !bus.dma_req && bus.cpu_req;
    end else begin
      cpu_gnt = bus.cpu_req;
      dma_gnt = !bus.cpu_req && bus.dma_req;
    end
  end

  assign dma_denied = (state_q == CPU_OWN) && bus.cpu_req && bus.dma_req;

  // RAM port mux; with no grant the CPU address is presented but nothing writes.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_wdata;
    if (dma_gnt) begin
      bus.ram_we   = bus.dma_we;
      bus.ram_addr = bus.dma_addr;
      bus.ram_din  = bus.dma_wdata;
    end else if (cpu_gnt) begin
      bus.ram_we   = bus.cpu_we;
    end
  end

  assign bus.cpu_rdata = bus.ram_dout;
  assign bus.dma_rdata = bus.ram_dout;
  assign bus.dma_ack   = dma_gnt;
  assign bus.cpu_stall = (state_q == DMA_OWN) && bus.dma_req && bus.cpu_req;
  assign bus.dma_owner = (state_q == DMA_OWN);

  // Next-state logic. A dropped dma_req always wins over takeover/burst
  // continuation, because dma_denied already requires dma_req.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == CPU_OWN) begin
      if (dma_denied) begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d     = DMA_OWN;
          burst_cnt_d = BURST_LAST;
          wait_cnt_d  = 4'd0;
        end else begin
          wait_cnt_d  = wait_cnt_q + 4'd1;
        end
      end else begin
        // Either DMA was acked this cycle or it is not requesting.
        wait_cnt_d = 4'd0;
      end
    end else begin
      wait_cnt_d = 4'd0;
      if (!bus.dma_req || burst_cnt_q == 4'd0) begin
        state_d     = CPU_OWN;
        burst_cnt_d = 4'd0;
      end else begin
        burst_cnt_d = burst_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= CPU_OWN;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef ARB_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'h0000;
    end else if (bus.cpu_stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Directed bench for dram_arbiter with default parameters (MAX_WAIT=4,
// BURST=2). A small word-addressed RAM model closes the RAM port. Inputs
// change 1 time unit after the rising edge; outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  dram_arbiter_if bus ();

  dram_arbiter #(.MAX_WAIT(4), .BURST(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // RAM model: synchronous write, combinational read.
  logic [31:0] mem [0:255];
  always @(posedge clk_i) begin
    if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_din;
  end
  assign bus.ram_dout = mem[bus.ram_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ARB_PERF_EN
  localparam logic [15:0] EXP_STALLS = 16'd2;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_0000;
    bus.cpu_wdata = 32'h0000_0000;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 32'h0000_0000;
    bus.dma_wdata = 32'h0000_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we);
    end
    n_checks++;
    if (bus.cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_cpu_stall got=%b exp=0", bus.cpu_stall);
    end
    n_checks++;
    if (bus.dma_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_dma_ack got=%b exp=0", bus.dma_ack);
    end
    n_checks++;
    if (bus.dma_owner !== 1'b0) begin
      n_fail++; $display("FAIL reset_dma_owner got=%b exp=0", bus.dma_owner);
    end
    n_checks++;
    if (bus.stall_cycles !== 16'h0000) begin
      n_fail++; $display("FAIL reset_stall_cycles got=%h exp=0000", bus.stall_cycles);
    end
    $display("test_reset done");
  endtask

  task automatic test_dma_write();
    do_reset();
    idle_inputs();
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 32'h0000_0040;
    bus.dma_wdata = 32'h0000_1234;
    bus.cpu_addr  = 32'h0000_0080;
    #1;
    n_checks++;
    if (bus.dma_ack !== 1'b1) begin
      n_fail++; $display("FAIL dmawr_ack got=%b exp=1", bus.dma_ack);
    end
    n_checks++;
    if (bus.ram_we !== 1'b1) begin
      n_fail++; $display("FAIL dmawr_ram_we got=%b exp=1", bus.ram_we);
    end
    n_checks++;
    if (bus.ram_addr !== 32'h0000_0040 || bus.ram_din !== 32'h0000_1234) begin
      n_fail++; $display("FAIL dmawr_ram_bus got=%h/%h exp=00000040/00001234",
                         bus.ram_addr, bus.ram_din);
    end
    step();
    bus.dma_req  = 1'b0;
    bus.dma_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0040;
    #1;
    n_checks++;
    if (bus.cpu_rdata !== 32'h0000_1234) begin
      n_fail++; $display("FAIL dmawr_cpu_read got=%h exp=00001234", bus.cpu_rdata);
    end
    n_checks++;
    if (bus.dma_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL dmawr_cpu_read_ctl got=ack%b/we%b exp=ack0/we0",
                         bus.dma_ack, bus.ram_we);
    end
    step();
    $display("test_dma_write done");
  endtask

  task automatic test_forced_burst();
    logic exp_own;
    do_reset();
    idle_inputs();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b1;
    bus.dma_addr = 32'h0000_0200;
    bus.dma_wdata = 32'hCAFE_0001;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_own = (c == 4 || c == 5);
      n_checks++;
      if (bus.dma_owner !== exp_own || bus.cpu_stall !== exp_own ||
          bus.dma_ack !== exp_own || bus.ram_we !== exp_own) begin
        n_fail++;
        $display("FAIL burst_cyc%0d got=own%b/stall%b/ack%b/we%b exp=all %b",
                 c, bus.dma_owner, bus.cpu_stall, bus.dma_ack, bus.ram_we, exp_own);
      end
      n_checks++;
      if (bus.ram_addr !== (exp_own ? 32'h0000_0200 : 32'h0000_0100)) begin
        n_fail++; $display("FAIL burst_addr_cyc%0d got=%h exp_own=%b",
                           c, bus.ram_addr, exp_own);
      end
      step();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_cycles !== EXP_STALLS) begin
      n_fail++; $display("FAIL burst_stall_cycles got=%0d exp=%0d",
                         bus.stall_cycles, EXP_STALLS);
    end
    $display("test_forced_burst done");
  endtask

  task automatic test_dma_drop();
    do_reset();
    idle_inputs();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0104;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 32'h0000_0204;
    for (int c = 0; c < 4; c++) step();
    #1;
    n_checks++;
    if (bus.dma_owner !== 1'b1) begin
      n_fail++; $display("FAIL drop_enter_owner got=%b exp=1", bus.dma_owner);
    end
    bus.dma_req = 1'b0;
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b0 || bus.dma_ack !== 1'b0 ||
        bus.ram_addr !== 32'h0000_0104) begin
      n_fail++; $display("FAIL drop_cpu_grant got=stall%b/ack%b/addr%h exp=0/0/00000104",
                         bus.cpu_stall, bus.dma_ack, bus.ram_addr);
    end
    step();
    n_checks++;
    if (bus.dma_owner !== 1'b0) begin
      n_fail++; $display("FAIL drop_exit_owner got=%b exp=0", bus.dma_owner);
    end
    $display("test_dma_drop done");
  endtask

  task automatic test_reset_mid_burst();
    logic exp_own;
    do_reset();
    idle_inputs();
    bus.cpu_req = 1'b1;
    bus.dma_req = 1'b1;
    bus.dma_we  = 1'b1;
    for (int c = 0; c < 4; c++) step();
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b1 || bus.dma_owner !== 1'b1) begin
      n_fail++; $display("FAIL midrst_before got=stall%b/own%b exp=1/1",
                         bus.cpu_stall, bus.dma_owner);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b0 || bus.dma_owner !== 1'b0 ||
        bus.dma_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got=stall%b/own%b/ack%b/we%b exp=0/0/0/0",
                         bus.cpu_stall, bus.dma_owner, bus.dma_ack, bus.ram_we);
    end
    n_checks++;
    if (bus.stall_cycles !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_stall_cycles got=%0d exp=0", bus.stall_cycles);
    end
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_own = (c == 4 || c == 5);
      n_checks++;
      if (bus.dma_owner !== exp_own || bus.cpu_stall !== exp_own) begin
        n_fail++; $display("FAIL midrst_restart_cyc%0d got=own%b/stall%b exp=%b",
                           c, bus.dma_owner, bus.cpu_stall, exp_own);
      end
      step();
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_alternate();
    logic exp_ack;
    do_reset();
    idle_inputs();
    bus.dma_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cpu_req = (c % 2 == 0);
      #1;
      exp_ack = (c % 2 != 0);
      n_checks++;
      if (bus.dma_ack !== exp_ack || bus.dma_owner !== 1'b0 ||
          bus.cpu_stall !== 1'b0) begin
        n_fail++; $display("FAIL alt_cyc%0d got=ack%b/own%b/stall%b exp=%b/0/0",
                           c, bus.dma_ack, bus.dma_owner, bus.cpu_stall, exp_ack);
      end
      step();
    end
    idle_inputs();
    $display("test_alternate done");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_dma_write();
    test_forced_burst();
    test_dma_drop();
    test_reset_mid_burst();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
